spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 slave: the far-end counterpart of the processor's SPI master engine. Allows one processor to be attached as a peripheral of another master.
- Oversamples SS_n, SCK and SI in the system clock domain, shifts MSB-first, and presents a byte-wide host interface (tx holding register, rx buffer, status register) in the same style as the master peripheral.
- Requires clk ≥ 4× SCK frequency.

Parameters:
- DUMMY, 8'hFF, byte shifted out when no tx byte is pending at a load point.
- SYNC_STAGES, 2, flop stages on SS_n/SCK/SI (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- EN  input  1  slave enable; 0 = ignore SS_n, hold SOen low
- SS_n  input  1  slave select from master, active-low
- SCK  input  1  serial clock from master, idles low
- SI  input  1  serial data from master (master's MO)
- SO  output  1  serial data to master (master's MI)
- SOen  output  1  SO drive enable (1 while frame active)
- wrBUF  input  1  host write strobe, loads bufIN into tx holding
- bufIN  input  8  host tx byte
- rdBUF  input  1  host read strobe, clears RXF
- bufOUT  output  8  last completed rx byte (registered)
- statREAD  input  1  host status read strobe, clears OVR
- statOUT  output  8  {BF, RXF, OVR, TXE, 4'b0000}

Behaviour:
- Reset: SO=1, SOen=0, bufOUT=00, BF=0, RXF=0, OVR=0, TXE=1, bit count=0, tx hold=DUMMY, sync flops=idle (SS_n=1, SCK=0).
- Edges are detected on synchronized signals: rise/fall = current vs previous synced sample. Latency is SYNC_STAGES+1 clk from pin to action.
- States: IDLE, ACTIVE.
- IDLE→ACTIVE on synced SS_n falling while EN=1:
  - tx shift ← tx hold if TXE=0, else DUMMY; TXE←1.
  - count←0, BF←1, SOen←1, SO=tx shift[7].
- ACTIVE, SCK rise:
  - rx shift ← {rx shift[6:0], SI_sync}; count←count+1.
  - On the 8th rise (count 7→0):
    - If RXF=0: bufOUT←assembled byte, RXF←1.
    - If RXF=1: bufOUT unchanged, OVR←1 (new byte discarded).
    - Reload tx shift as at frame start, for a back-to-back byte in the same frame.
- ACTIVE, SCK fall: if count≠0, tx shift ← {tx shift[6:0],1}. If count==0, no shift, so the freshly loaded MSB is held. SO=tx shift[7] at all times.
- ACTIVE→IDLE on synced SS_n rising, or EN=0:
  - Partial byte discarded; count←0; BF←0; SOen←0; SO←1.
  - RXF/OVR/TXE/tx hold unchanged.
- SCK edges in IDLE are ignored.
- wrBUF: tx hold←bufIN, TXE←0, in any state. If it coincides with a load point, the load uses the old hold/TXE, then the write is stored: TXE ends 0, hold = new byte.
- rdBUF: RXF←0 next cycle. If it coincides with a byte completion, completion wins: bufOUT updated, RXF=1, no OVR.
- statREAD: OVR←0 next cycle. A simultaneous overrun event wins (OVR=1).
- statOUT is registered and reflects flags one cycle after they change.
- Reset asserted mid-frame: immediate return to reset values; the frame is abandoned.

Test Plan:
- Single byte: wrBUF bufIN=A5; SS_n low; master clocks 3C MSB-first; SS_n high → SO sequence 1,0,1,0,0,1,0,1; bufOUT=3C; statOUT=0x50 (RXF, TXE set) after frame, 0xD0 during last bits; BF=0 after SS_n high.
- Underrun/dummy: no wrBUF, frame of 8 clocks → SO shifts FF; TXE stays 1.
- Back-to-back: wrBUF 11, frame start, wrBUF 22 mid-byte, 16 SCK in one frame, master sends 81,7E, rdBUF after first byte → SO bytes 11 then 22; bufOUT 81 then 7E; OVR=0.
- Overrun: two bytes without rdBUF → bufOUT holds first byte; OVR=1; statREAD clears OVR; rdBUF clears RXF.
- Abort: SS_n high after 5 SCK → bufOUT unchanged; RXF unchanged; next frame starts count at 0 with correct MSB.
- Reset mid-frame (rst_n low after 3 bits) → all outputs at reset values asynchronously; next full frame transfers correctly.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode-0 slave peripheral. SS_n, SCK and SI are oversampled in the system
// clock domain. Data shifts MSB-first: SI is captured on SCK rise and SO
// advances on SCK fall. The host side is byte-wide: a tx holding register, an
// rx buffer and a status register. clk must run at least 4x the SCK rate.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   EN        slave enable; when low, SS_n is ignored and SOen is held low
//   SS_n      slave select from the master, active-low
//   SCK       serial clock from the master, idles low
//   SI        serial data from the master
//   SO        serial data to the master (1 when not selected)
//   SOen      SO drive enable, high while a frame is active
//   wrBUF     host write strobe; loads bufIN into the tx holding register
//   bufIN     host tx byte
//   rdBUF     host read strobe; clears RXF
//   bufOUT    last completed rx byte
//   statREAD  host status read strobe; clears OVR
//   statOUT   {BF, RXF, OVR, TXE, 4'b0000}, registered
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter logic [7:0] DUMMY       = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic       SS_n,
    input  logic       SCK,
    input  logic       SI,
    output logic       SO,
    output logic       SOen,
    input  logic       wrBUF,
    input  logic [7:0] bufIN,
    input  logic       rdBUF,
    output logic [7:0] bufOUT,
    input  logic       statREAD,
    output logic [7:0] statOUT
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, nextState;

    logic [SYNC_STAGES-1:0] ssPipe, sckPipe, siPipe;
    logic ssPrev, sckPrev;
    logic ssS, sckS, siS;
    logic ssFall, ssRise, sckRise, sckFall;

    logic [7:0] txHold, txShift, bufReg, statReg;
    logic [6:0] rxShift;
    logic [2:0] bitCnt;
    logic       txe, rxf, ovr, bf, soEnReg;

    logic       startFrame, endFrame, shiftIn, shiftOut;
    logic       byteDone, loadPoint, rxFree;
    logic [7:0] loadByte, rxNext;

    // Synchronizers plus one extra sample of each synced signal for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssPipe  <= '1;
            sckPipe <= '0;
            siPipe  <= '0;
            ssPrev  <= 1'b1;
            sckPrev <= 1'b0;
        end else begin
            ssPipe  <= {ssPipe[SYNC_STAGES-2:0], SS_n};
            sckPipe <= {sckPipe[SYNC_STAGES-2:0], SCK};
            siPipe  <= {siPipe[SYNC_STAGES-2:0], SI};
            ssPrev  <= ssS;
            sckPrev <= sckS;
        end
    end

    assign ssS     = ssPipe[SYNC_STAGES-1];
    assign sckS    = sckPipe[SYNC_STAGES-1];
    assign siS     = siPipe[SYNC_STAGES-1];
    assign ssFall  = ssPrev & ~ssS;
    assign ssRise  = ~ssPrev & ssS;
    assign sckRise = ~sckPrev & sckS;
    assign sckFall = sckPrev & ~sckS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        startFrame = 1'b0;
        endFrame   = 1'b0;
        shiftIn    = 1'b0;
        shiftOut   = 1'b0;
        case (state)
            IDLE: begin
                if (EN && ssFall) begin
                    nextState  = ACTIVE;
                    startFrame = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect or disable takes priority over any SCK edge.
                if (!EN || ssRise) begin
                    nextState = IDLE;
                    endFrame  = 1'b1;
                end else begin
                    shiftIn  = sckRise;
                    shiftOut = sckFall;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign rxNext    = {rxShift, siS};
    assign byteDone  = shiftIn && (bitCnt == 3'd7);
    assign loadPoint = startFrame || byteDone;
    assign loadByte  = txe ? DUMMY : txHold;
    // A host read in the same cycle as a completion frees the buffer first.
    assign rxFree    = !rxf || rdBUF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txHold  <= DUMMY;
            txShift <= DUMMY;
            rxShift <= '0;
            bufReg  <= '0;
            bitCnt  <= '0;
            txe     <= 1'b1;
            rxf     <= 1'b0;
            ovr     <= 1'b0;
            bf      <= 1'b0;
            soEnReg <= 1'b0;
            statReg <= 8'h10;
        end else begin
            if (wrBUF) begin
                txHold <= bufIN;
            end

            // A load point consumes the old hold/TXE; a coincident write still lands.
            if (wrBUF) begin
                txe <= 1'b0;
            end else if (loadPoint) begin
                txe <= 1'b1;
            end

            if (startFrame) begin
                txShift <= loadByte;
                bitCnt  <= '0;
                bf      <= 1'b1;
                soEnReg <= 1'b1;
            end

            if (endFrame) begin
                bitCnt  <= '0;
                bf      <= 1'b0;
                soEnReg <= 1'b0;
            end

            if (shiftIn) begin
                rxShift <= rxNext[6:0];
                bitCnt  <= bitCnt + 3'd1;
            end

            if (byteDone) begin
                txShift <= loadByte;
                if (rxFree) begin
                    bufReg <= rxNext;
                end
            end

            // At count 0 the freshly loaded MSB must stay on SO until the next rise.
            if (shiftOut && (bitCnt != 3'd0)) begin
                txShift <= {txShift[6:0], 1'b1};
            end

            if (byteDone && rxFree) begin
                rxf <= 1'b1;
            end else if (rdBUF) begin
                rxf <= 1'b0;
            end

            if (byteDone && !rxFree) begin
                ovr <= 1'b1;
            end else if (statREAD) begin
                ovr <= 1'b0;
            end

            statReg <= {bf, rxf, ovr, txe, 4'b0000};
        end
    end

    assign SO      = soEnReg ? txShift[7] : 1'b1;
    assign SOen    = soEnReg;
    assign bufOUT  = bufReg;
    assign statOUT = statReg;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave. A simple mode-0 master model drives SS_n, SCK
// and SI with eight system clocks per SCK period and samples SO just before
// each SCK rise. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       EN;
    logic       SS_n;
    logic       SCK;
    logic       SI;
    logic       SO;
    logic       SOen;
    logic       wrBUF;
    logic [7:0] bufIN;
    logic       rdBUF;
    logic [7:0] bufOUT;
    logic       statREAD;
    logic [7:0] statOUT;

    int vecCnt;
    int missCnt;

    logic [7:0] mi;

    spi_slave #(
        .DUMMY      (8'hFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .EN      (EN),
        .SS_n    (SS_n),
        .SCK     (SCK),
        .SI      (SI),
        .SO      (SO),
        .SOen    (SOen),
        .wrBUF   (wrBUF),
        .bufIN   (bufIN),
        .rdBUF   (rdBUF),
        .bufOUT  (bufOUT),
        .statREAD(statREAD),
        .statOUT (statOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vecCnt++;
        if (observed !== expected) begin
            missCnt++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hostWrite(input logic [7:0] b);
        wrBUF = 1'b1;
        bufIN = b;
        waitClk(1);
        wrBUF = 1'b0;
        waitClk(2);
    endtask

    task automatic hostRead();
        rdBUF = 1'b1;
        waitClk(1);
        rdBUF = 1'b0;
        waitClk(2);
    endtask

    task automatic hostStat();
        statREAD = 1'b1;
        waitClk(1);
        statREAD = 1'b0;
        waitClk(2);
    endtask

    // Shifts nBits of mo MSB-first; optionally performs a host write while
    // SCK is high on bit 4. Returns what was seen on SO.
    task automatic sendBits(input logic [7:0] mo, input int nBits, input bit doWr,
                            input logic [7:0] w, output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 7; i > 7 - nBits; i--) begin
            SI = mo[i];
            waitClk(4);
            seen[i] = SO;
            SCK = 1'b1;
            waitClk(1);
            if (doWr && i == 4) begin
                wrBUF = 1'b1;
                bufIN = w;
            end
            waitClk(1);
            wrBUF = 1'b0;
            waitClk(2);
            SCK = 1'b0;
        end
        waitClk(4);
    endtask

    task automatic frameStart();
        SS_n = 1'b0;
        waitClk(6);
    endtask

    task automatic frameEnd();
        SS_n = 1'b1;
        waitClk(6);
    endtask

    initial begin
        vecCnt   = 0;
        missCnt  = 0;
        rst_n    = 1'b0;
        EN       = 1'b1;
        SS_n     = 1'b1;
        SCK      = 1'b0;
        SI       = 1'b0;
        wrBUF    = 1'b0;
        bufIN    = 8'h00;
        rdBUF    = 1'b0;
        statREAD = 1'b0;

        waitClk(3);
        checkVal("rst SO", {7'd0, SO}, 8'h01);
        checkVal("rst SOen", {7'd0, SOen}, 8'h00);
        checkVal("rst bufOUT", bufOUT, 8'h00);
        checkVal("rst statOUT", statOUT, 8'h10);
        rst_n = 1'b1;
        waitClk(3);

        // Single byte: slave returns A5, master sends 3C
        hostWrite(8'hA5);
        checkVal("wr statOUT", statOUT, 8'h00);
        frameStart();
        checkVal("start SOen", {7'd0, SOen}, 8'h01);
        checkVal("start statOUT", statOUT, 8'h90);
        sendBits(8'h3C, 8, 1'b0, 8'h00, mi);
        checkVal("single SO byte", mi, 8'hA5);
        checkVal("single last statOUT", statOUT, 8'hD0);
        checkVal("single bufOUT", bufOUT, 8'h3C);
        frameEnd();
        checkVal("single end SOen", {7'd0, SOen}, 8'h00);
        checkVal("single end SO", {7'd0, SO}, 8'h01);
        checkVal("single end statOUT", statOUT, 8'h50);

        // Underrun: no pending byte, dummy goes out
        hostRead();
        frameStart();
        sendBits(8'h5A, 8, 1'b0, 8'h00, mi);
        frameEnd();
        checkVal("dummy SO byte", mi, 8'hFF);
        checkVal("dummy bufOUT", bufOUT, 8'h5A);
        checkVal("dummy statOUT", statOUT, 8'h50);

        // Back-to-back bytes in one frame with a mid-byte host write
        hostRead();
        hostWrite(8'h11);
        frameStart();
        sendBits(8'h81, 8, 1'b1, 8'h22, mi);
        checkVal("b2b SO byte0", mi, 8'h11);
        checkVal("b2b bufOUT0", bufOUT, 8'h81);
        hostRead();
        sendBits(8'h7E, 8, 1'b0, 8'h00, mi);
        checkVal("b2b SO byte1", mi, 8'h22);
        frameEnd();
        checkVal("b2b bufOUT1", bufOUT, 8'h7E);
        checkVal("b2b statOUT", statOUT, 8'h50);

        // Overrun: two bytes without a host read
        hostRead();
        frameStart();
        sendBits(8'hC3, 8, 1'b0, 8'h00, mi);
        sendBits(8'h99, 8, 1'b0, 8'h00, mi);
        frameEnd();
        checkVal("ovr bufOUT", bufOUT, 8'hC3);
        checkVal("ovr statOUT", statOUT, 8'h70);
        hostStat();
        checkVal("ovr cleared statOUT", statOUT, 8'h50);
        hostRead();
        checkVal("rxf cleared statOUT", statOUT, 8'h10);

        // Abort after five bits, then a full frame
        hostWrite(8'h6B);
        frameStart();
        sendBits(8'hF0, 5, 1'b0, 8'h00, mi);
        frameEnd();
        checkVal("abort SO bits", mi & 8'hF8, 8'h68);
        checkVal("abort bufOUT", bufOUT, 8'hC3);
        checkVal("abort statOUT", statOUT, 8'h10);
        hostWrite(8'h96);
        frameStart();
        sendBits(8'h0F, 8, 1'b0, 8'h00, mi);
        frameEnd();
        checkVal("post-abort SO byte", mi, 8'h96);
        checkVal("post-abort bufOUT", bufOUT, 8'h0F);

        // Reset in the middle of a frame
        hostWrite(8'hA5);
        frameStart();
        sendBits(8'h33, 3, 1'b0, 8'h00, mi);
        checkVal("pre-rst SOen", {7'd0, SOen}, 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("midrst SO", {7'd0, SO}, 8'h01);
        checkVal("midrst SOen", {7'd0, SOen}, 8'h00);
        checkVal("midrst bufOUT", bufOUT, 8'h00);
        checkVal("midrst statOUT", statOUT, 8'h10);
        SS_n = 1'b1;
        SCK  = 1'b0;
        waitClk(2);
        rst_n = 1'b1;
        waitClk(3);
        hostWrite(8'h5C);
        frameStart();
        sendBits(8'hE7, 8, 1'b0, 8'h00, mi);
        frameEnd();
        checkVal("post-rst SO byte", mi, 8'h5C);
        checkVal("post-rst bufOUT", bufOUT, 8'hE7);
        checkVal("post-rst statOUT", statOUT, 8'h50);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
